combat_resolver: RTL and testbench
==================================

// Module: combat_resolver
// PURPOSE
//  Battlefront calculator for the lane. Sits between the unit bank and the enemy bank.
//  Per game tick it does the following, in order:
//   - finds the frontmost live unit and the frontmost live enemy,
//   - pulses moveSCEN,
//   - sums live attackers' damageOut per side,
//   - pulses damageSCEN, routing each side's total only to the opposing front entity.
//  Units march down from 511; enemies march up from 0.
// PARAMETERS
//  NUM_UNITS    4        unit slots scanned
//  NUM_ENEMIES  4        enemy slots scanned
//  TICK_DIV     2000000  clk cycles per game tick (>=1)
// PORTS
//  clk           in   1             system clock
//  reset         in   1             asynchronous, active-high
//  enable        in   1             gates tick counter (pause)
//  unitPos       in   9*NUM_UNITS   flattened unit positions, slot i at [9i+:9]
//  unitType      in   2*NUM_UNITS   00 = dead, 1-3 = live type
//  unitDmgOut    in   8*NUM_UNITS   unit damageOut
//  enemyPos      in   9*NUM_ENEMIES enemy positions
//  enemyType     in   2*NUM_ENEMIES 00 = dead
//  enemyDmgOut   in   8*NUM_ENEMIES enemy damageOut
//  moveSCEN      out  1             1-cycle move strobe to all units/enemies
//  damageSCEN    out  1             1-cycle damage strobe to all units/enemies
//  enemyFront    out  9             max pos of live enemies, to units
//  unitFront     out  9             min pos of live units, to enemies
//  unitDmgIn     out  8*NUM_UNITS   damage to each unit
//  enemyDmgIn    out  8*NUM_ENEMIES damage to each enemy
// BEHAVIOUR
//  Reset values (async, immediate):
//   - state = WAIT, tick counter = 0
//   - moveSCEN = damageSCEN = 0, all DmgIn = 0
//   - enemyFront = 0, unitFront = 511
//  FSM: WAIT -> FSCAN -> MOVE -> SSCAN -> HIT -> WAIT.
//  WAIT:
//   - counts while enable = 1; holds while enable = 0.
//   - at count TICK_DIV-1: clear counter, go to FSCAN.
//  FSCAN:
//   - one slot index per cycle, over max(NUM_UNITS, NUM_ENEMIES) cycles.
//   - slots with type 00, or index beyond the side's count, are ignored.
//   - ties: lowest index wins.
//   - at scan end, register enemyFront/unitFront and the target indices.
//   - no live enemy: enemyFront = 0, no enemy target. No live unit: unitFront = 511, no unit target.
//   - front outputs hold stable between scans.
//  MOVE:
//   - moveSCEN = 1 for exactly one cycle, then SSCAN.
//  SSCAN:
//   - same walk as FSCAN; accumulates live unitDmgOut and live enemyDmgOut.
//   - runs after MOVE, so it sees damageOut updated at the MOVE edge.
//   - 8-bit saturating add: clamps at 255, never wraps.
//   - slots that died since FSCAN (type 00) are skipped.
//  HIT:
//   - damageSCEN = 1 for exactly one cycle.
//   - enemy target's enemyDmgIn = unit sum; unit target's unitDmgIn = enemy sum.
//   - if the target's type is now 00, or there is no target, that sum is dropped.
//  DmgIn outputs are 0 in every cycle except HIT. This is mandatory: units compare health
//  against damageIn every cycle.
//  Tick latency: TICK_DIV + 2*max(N) + 2 cycles per full tick.
//  enable = 0 mid-sequence: the current sequence completes; only WAIT is paused.
//  Reset mid-operation: abort to reset values, no partial strobe.
//  Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared package (battle_pkg):
//   - POS_W = 9, DMG_W = 8, TYPE_W = 2
//   - TYPE_DEAD = 2'b00
//   - POS_UNIT_SPAWN = 9'd511, POS_ENEMY_SPAWN = 9'd0
//   - DMG_MAX = 8'd255
//  One sub-module, game_tick_gen: TICK_DIV counter with enable, 1-cycle tick pulse.
//  Scan datapath and FSM stay in this module.
// TESTING  (TICK_DIV = 4, N = 4 both sides)
//  1. Reset asserted mid-SSCAN -> moveSCEN = damageSCEN = 0, DmgIn all 0, enemyFront = 0,
//     unitFront = 511 the same cycle; next moveSCEN exactly 4 + 4 cycles after release.
//  2. Unit pos {300,250,250,dead}, enemy pos {100,dead,180,180} -> unitFront = 250,
//     enemyFront = 180; targets are unit slot 1 and enemy slot 2 (tie -> lowest index).
//  3. Unit dmgOut {0x80,0x80,0x40,x} all live -> enemyDmgIn[2] = 255 (saturated) only
//     during the damageSCEN cycle; 0 in every other cycle and slot.
//  4. All enemies dead -> enemyFront = 0; HIT cycle has enemyDmgIn all 0; enemy damage
//     to units still applied.
//  5. enable low for 10 cycles during WAIT -> move strobe delayed by exactly 10 cycles;
//     enable dropped during FSCAN -> that sequence still issues MOVE and HIT.
//  6. Unit target's type goes to 00 during SSCAN -> its unitDmgIn = 0 at HIT; moveSCEN and
//     damageSCEN are each 1-cycle pulses, never simultaneous.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared lane-battle types and constants used by the combat resolver.
package battle_pkg;

  localparam int POS_W  = 9;
  localparam int DMG_W  = 8;
  localparam int TYPE_W = 2;

  localparam logic [TYPE_W-1:0] TYPE_DEAD       = 2'b00;
  localparam logic [POS_W-1:0]  POS_UNIT_SPAWN  = 9'd511;
  localparam logic [POS_W-1:0]  POS_ENEMY_SPAWN = 9'd0;
  localparam logic [DMG_W-1:0]  DMG_MAX         = 8'd255;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_FSCAN,
    ST_MOVE,
    ST_SSCAN,
    ST_HIT
  } state_t;

endpackage

// File: rtl/game_tick_gen.sv
// Game tick divider: counts enabled clk cycles, pulses tick on the last one.
module game_tick_gen #(
  parameter int TICK_DIV = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_W'(TICK_DIV - 1));

  // Advance while enabled, wrap to zero on the tick cycle, hold when paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/combat_resolver.sv
// Lane battlefront calculator: per game tick finds both fronts, strobes a move,
// sums live attackers' damage per side and delivers it to the opposing front.
module combat_resolver
  import battle_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int NUM_ENEMIES = 4,
  parameter int TICK_DIV    = 2000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [POS_W*NUM_UNITS-1:0]     unitPos,
  input  logic [TYPE_W*NUM_UNITS-1:0]    unitType,
  input  logic [DMG_W*NUM_UNITS-1:0]     unitDmgOut,
  input  logic [POS_W*NUM_ENEMIES-1:0]   enemyPos,
  input  logic [TYPE_W*NUM_ENEMIES-1:0]  enemyType,
  input  logic [DMG_W*NUM_ENEMIES-1:0]   enemyDmgOut,
  output logic                           moveSCEN,
  output logic                           damageSCEN,
  output logic [POS_W-1:0]               enemyFront,
  output logic [POS_W-1:0]               unitFront,
  output logic [DMG_W*NUM_UNITS-1:0]     unitDmgIn,
  output logic [DMG_W*NUM_ENEMIES-1:0]   enemyDmgIn
);

  localparam int MAXN  = (NUM_UNITS > NUM_ENEMIES) ? NUM_UNITS : NUM_ENEMIES;
  localparam int IDX_W = (MAXN > 1) ? $clog2(MAXN) : 1;

  function automatic logic [DMG_W-1:0] sat_add(input logic [DMG_W-1:0] a,
                                               input logic [DMG_W-1:0] b);
    logic [DMG_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DMG_W] ? DMG_MAX : s[DMG_W-1:0];
  endfunction

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             tick;

  // Both sides padded to MAXN slots; slots past a side's count read as dead.
  logic [POS_W-1:0] u_pos [MAXN];
  logic             u_live[MAXN];
  logic [DMG_W-1:0] u_dmg [MAXN];
  logic [POS_W-1:0] e_pos [MAXN];
  logic             e_live[MAXN];
  logic [DMG_W-1:0] e_dmg [MAXN];

  for (genvar gi = 0; gi < MAXN; gi++) begin : g_slot
    if (gi < NUM_UNITS) begin : g_u
      assign u_pos[gi]  = unitPos[POS_W*gi +: POS_W];
      assign u_live[gi] = unitType[TYPE_W*gi +: TYPE_W] != TYPE_DEAD;
      assign u_dmg[gi]  = unitDmgOut[DMG_W*gi +: DMG_W];
    end else begin : g_u_pad
      assign u_pos[gi]  = '0;
      assign u_live[gi] = 1'b0;
      assign u_dmg[gi]  = '0;
    end
    if (gi < NUM_ENEMIES) begin : g_e
      assign e_pos[gi]  = enemyPos[POS_W*gi +: POS_W];
      assign e_live[gi] = enemyType[TYPE_W*gi +: TYPE_W] != TYPE_DEAD;
      assign e_dmg[gi]  = enemyDmgOut[DMG_W*gi +: DMG_W];
    end else begin : g_e_pad
      assign e_pos[gi]  = '0;
      assign e_live[gi] = 1'b0;
      assign e_dmg[gi]  = '0;
    end
  end

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable && (state == ST_WAIT)),
    .tick   (tick)
  );

  // Running scan results; the *_n values include the slot under idx this cycle.
  logic             u_fnd,  e_fnd,  u_fnd_n,  e_fnd_n;
  logic [POS_W-1:0] u_bpos, e_bpos, u_bpos_n, e_bpos_n;
  logic [IDX_W-1:0] u_bidx, e_bidx, u_bidx_n, e_bidx_n;
  logic [DMG_W-1:0] u_sum,  e_sum,  u_sum_n,  e_sum_n;

  logic             u_tgt_vld, e_tgt_vld;
  logic [IDX_W-1:0] u_tgt, e_tgt;

  assign last = (idx == IDX_W'(MAXN - 1));

  // Fold the current slot into the front search (strict compare keeps lowest index on ties) and damage sums.
  always_comb begin
    u_fnd_n  = u_fnd;
    u_bpos_n = u_bpos;
    u_bidx_n = u_bidx;
    e_fnd_n  = e_fnd;
    e_bpos_n = e_bpos;
    e_bidx_n = e_bidx;
    if (u_live[idx] && (!u_fnd || (u_pos[idx] < u_bpos))) begin
      u_fnd_n  = 1'b1;
      u_bpos_n = u_pos[idx];
      u_bidx_n = idx;
    end
    if (e_live[idx] && (!e_fnd || (e_pos[idx] > e_bpos))) begin
      e_fnd_n  = 1'b1;
      e_bpos_n = e_pos[idx];
      e_bidx_n = idx;
    end
    u_sum_n = u_live[idx] ? sat_add(u_sum, u_dmg[idx]) : u_sum;
    e_sum_n = e_live[idx] ? sat_add(e_sum, e_dmg[idx]) : e_sum;
  end

  // Scan accumulators: cleared ahead of each walk, so they need no reset.
  always_ff @(posedge clk) begin
    case (state)
      ST_WAIT: begin
        u_fnd <= 1'b0;
        e_fnd <= 1'b0;
      end
      ST_FSCAN: begin
        u_fnd  <= u_fnd_n;
        u_bpos <= u_bpos_n;
        u_bidx <= u_bidx_n;
        e_fnd  <= e_fnd_n;
        e_bpos <= e_bpos_n;
        e_bidx <= e_bidx_n;
      end
      ST_MOVE: begin
        u_sum <= '0;
        e_sum <= '0;
      end
      ST_SSCAN: begin
        u_sum <= u_sum_n;
        e_sum <= e_sum_n;
      end
      default: ;
    endcase
  end

  // Tick sequencer with registered strobes, fronts, targets and damage outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_WAIT;
      idx        <= '0;
      moveSCEN   <= 1'b0;
      damageSCEN <= 1'b0;
      unitDmgIn  <= '0;
      enemyDmgIn <= '0;
      enemyFront <= POS_ENEMY_SPAWN;
      unitFront  <= POS_UNIT_SPAWN;
      u_tgt_vld  <= 1'b0;
      e_tgt_vld  <= 1'b0;
      u_tgt      <= '0;
      e_tgt      <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          idx <= '0;
          if (tick) state <= ST_FSCAN;
        end
        ST_FSCAN: begin
          if (last) begin
            unitFront  <= u_fnd_n ? u_bpos_n : POS_UNIT_SPAWN;
            enemyFront <= e_fnd_n ? e_bpos_n : POS_ENEMY_SPAWN;
            u_tgt_vld  <= u_fnd_n;
            u_tgt      <= u_bidx_n;
            e_tgt_vld  <= e_fnd_n;
            e_tgt      <= e_bidx_n;
            moveSCEN   <= 1'b1;
            idx        <= '0;
            state      <= ST_MOVE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_MOVE: begin
          moveSCEN <= 1'b0;
          state    <= ST_SSCAN;
        end
        ST_SSCAN: begin
          if (last) begin
            damageSCEN <= 1'b1;
            unitDmgIn  <= '0;
            enemyDmgIn <= '0;
            for (int i = 0; i < NUM_UNITS; i++)
              if (u_tgt_vld && (u_tgt == IDX_W'(i)) && u_live[i])
                unitDmgIn[DMG_W*i +: DMG_W] <= e_sum_n;
            for (int i = 0; i < NUM_ENEMIES; i++)
              if (e_tgt_vld && (e_tgt == IDX_W'(i)) && e_live[i])
                enemyDmgIn[DMG_W*i +: DMG_W] <= u_sum_n;
            idx   <= '0;
            state <= ST_HIT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_HIT: begin
          damageSCEN <= 1'b0;
          unitDmgIn  <= '0;
          enemyDmgIn <= '0;
          state      <= ST_WAIT;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver with TICK_DIV = 4 and four slots per side.
module tb_combat_resolver;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [35:0]   unitPos, enemyPos;
  logic [7:0]    unitType, enemyType;
  logic [31:0]   unitDmgOut, enemyDmgOut;
  logic          moveSCEN, damageSCEN;
  logic [8:0]    enemyFront, unitFront;
  logic [31:0]   unitDmgIn, enemyDmgIn;

  combat_resolver #(.NUM_UNITS(N), .NUM_ENEMIES(N), .TICK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .unitPos     (unitPos),
    .unitType    (unitType),
    .unitDmgOut  (unitDmgOut),
    .enemyPos    (enemyPos),
    .enemyType   (enemyType),
    .enemyDmgOut (enemyDmgOut),
    .moveSCEN    (moveSCEN),
    .damageSCEN  (damageSCEN),
    .enemyFront  (enemyFront),
    .unitFront   (unitFront),
    .unitDmgIn   (unitDmgIn),
    .enemyDmgIn  (enemyDmgIn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] upos;
    logic [7:0]  utype;
    logic [31:0] udmg;
    logic [35:0] epos;
    logic [7:0]  etype;
    logic [31:0] edmg;
    logic [8:0]  exp_uf;
    logic [8:0]  exp_ef;
    logic [31:0] exp_udi;
    logic [31:0] exp_edi;
  } vec_t;

  vec_t vec [5];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_on = 1'b0;
  logic prev_move = 1'b0;
  logic prev_dmg = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int k);
    unitPos     = vec[k].upos;
    unitType    = vec[k].utype;
    unitDmgOut  = vec[k].udmg;
    enemyPos    = vec[k].epos;
    enemyType   = vec[k].etype;
    enemyDmgOut = vec[k].edmg;
  endtask

  // Wait (on negedges) for moveSCEN (sel 0) or damageSCEN (sel 1); -1 on timeout.
  task automatic wait_sig(input int sel, input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if ((sel == 0 && moveSCEN) || (sel == 1 && damageSCEN)) begin
        cyc = c;
        break;
      end
    end
  endtask

  // Continuous checks: DmgIn is zero outside the damage strobe, strobes are single-cycle and disjoint.
  always @(negedge clk) begin
    if (mon_on) begin
      if (!damageSCEN) begin
        n_cmp++;
        if (unitDmgIn !== 32'd0 || enemyDmgIn !== 32'd0) begin
          n_bad++;
          $display("FAIL dmgin_idle: got %0h/%0h, want 0/0", unitDmgIn, enemyDmgIn);
        end
      end
      n_cmp++;
      if ((moveSCEN && damageSCEN) || (moveSCEN && prev_move) || (damageSCEN && prev_dmg)) begin
        n_bad++;
        $display("FAIL strobe_shape: move %0b dmg %0b prev %0b/%0b, want single disjoint pulses",
                 moveSCEN, damageSCEN, prev_move, prev_dmg);
      end
    end
    prev_move = moveSCEN;
    prev_dmg  = damageSCEN;
  end

  initial begin
    int cyc;
    int hits;

    // A: mixed fronts with ties and dead slots; unit damage saturates.
    vec[0] = '{upos: {9'd10, 9'd250, 9'd250, 9'd300}, utype: 8'h1B,
               udmg: {8'hFF, 8'h40, 8'h80, 8'h80},
               epos: {9'd180, 9'd180, 9'd400, 9'd100}, etype: 8'h61,
               edmg: {8'd9, 8'd7, 8'd99, 8'd5},
               exp_uf: 9'd250, exp_ef: 9'd180, exp_udi: 32'h0000_1500, exp_edi: 32'h00FF_0000};
    // B: all live, enemies all at 0 (front 0 but target slot 0), no saturation.
    vec[1] = '{upos: {9'd20, 9'd300, 9'd20, 9'd500}, utype: 8'hFF,
               udmg: {8'd4, 8'd3, 8'd2, 8'd1},
               epos: 36'd0, etype: 8'h55,
               edmg: {8'd40, 8'd30, 8'd20, 8'd10},
               exp_uf: 9'd20, exp_ef: 9'd0, exp_udi: 32'h0000_6400, exp_edi: 32'h0000_000A};
    // C: all enemies dead.
    vec[2] = '{upos: {9'd511, 9'd200, 9'd100, 9'd400}, utype: 8'h55,
               udmg: {8'd9, 8'd9, 8'd9, 8'd9},
               epos: {9'd80, 9'd70, 9'd60, 9'd50}, etype: 8'h00,
               edmg: {8'd1, 8'd1, 8'd1, 8'd1},
               exp_uf: 9'd100, exp_ef: 9'd0, exp_udi: 32'h0, exp_edi: 32'h0};
    // D: all units dead.
    vec[3] = '{upos: {9'd1, 9'd2, 9'd3, 9'd4}, utype: 8'h00,
               udmg: {8'd50, 8'd50, 8'd50, 8'd50},
               epos: {9'd200, 9'd100, 9'd200, 9'd30}, etype: 8'hFF,
               edmg: {8'd6, 8'd5, 8'd4, 8'd3},
               exp_uf: 9'd511, exp_ef: 9'd200, exp_udi: 32'h0, exp_edi: 32'h0};
    // E: extreme positions, only high slots live, enemy damage saturates.
    vec[4] = '{upos: {9'd0, 9'd5, 9'd5, 9'd5}, utype: 8'h80,
               udmg: {8'd255, 8'd7, 8'd7, 8'd7},
               epos: {9'd511, 9'd511, 9'd300, 9'd300}, etype: 8'h70,
               edmg: {8'd100, 8'd200, 8'd1, 8'd1},
               exp_uf: 9'd0, exp_ef: 9'd511, exp_udi: 32'hFF00_0000, exp_edi: 32'h00FF_0000};

    reset  = 1'b1;
    enable = 1'b1;
    apply(0);
    repeat (3) @(negedge clk);
    chk("rst_move",   64'(moveSCEN),   64'd0);
    chk("rst_dmg",    64'(damageSCEN), 64'd0);
    chk("rst_efront", 64'(enemyFront), 64'd0);
    chk("rst_ufront", 64'(unitFront),  64'd511);
    chk("rst_dmgin",  64'({unitDmgIn, enemyDmgIn}), 64'd0);
    reset  = 1'b0;
    mon_on = 1'b1;

    // Table: one game tick per vector.
    for (int k = 0; k < 5; k++) begin
      wait_sig(0, 40, cyc);
      chk($sformatf("v%0d_move_lat", k), 64'(cyc), (k == 0) ? 64'd8 : 64'd9);
      chk($sformatf("v%0d_ufront", k), 64'(unitFront),  64'(vec[k].exp_uf));
      chk($sformatf("v%0d_efront", k), 64'(enemyFront), 64'(vec[k].exp_ef));
      wait_sig(1, 40, cyc);
      chk($sformatf("v%0d_dmg_lat", k), 64'(cyc), 64'd5);
      chk($sformatf("v%0d_udmgin", k), 64'(unitDmgIn),  64'(vec[k].exp_udi));
      chk($sformatf("v%0d_edmgin", k), 64'(enemyDmgIn), 64'(vec[k].exp_edi));
      if (k < 4) apply(k + 1);
    end

    // Reset asserted mid-SSCAN.
    apply(0);
    wait_sig(0, 40, cyc);
    chk("t1_pre_ufront", 64'(unitFront), 64'd250);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t1_move",   64'(moveSCEN),   64'd0);
    chk("t1_dmg",    64'(damageSCEN), 64'd0);
    chk("t1_efront", 64'(enemyFront), 64'd0);
    chk("t1_ufront", 64'(unitFront),  64'd511);
    chk("t1_dmgin",  64'({unitDmgIn, enemyDmgIn}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_sig(0, 40, cyc);
    chk("t1_move_lat", 64'(cyc), 64'd8);
    wait_sig(1, 40, cyc);
    chk("t1_edmgin", 64'(enemyDmgIn), 64'h00FF_0000);
    chk("t1_udmgin", 64'(unitDmgIn),  64'h0000_1500);

    // Pause for 10 cycles in WAIT.
    @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    wait_sig(0, 40, cyc);
    chk("t5_pause_lat", 64'(cyc + 11), 64'd19);
    wait_sig(1, 40, cyc);
    chk("t5_pause_dmg_lat", 64'(cyc), 64'd5);

    // Drop enable during FSCAN: that sequence still completes.
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 6) enable = 1'b0;
      if (moveSCEN) begin
        cyc = c;
        break;
      end
    end
    chk("t5_fscan_move_lat", 64'(cyc), 64'd9);
    wait_sig(1, 40, cyc);
    chk("t5_fscan_dmg_lat", 64'(cyc), 64'd5);
    chk("t5_fscan_edmgin", 64'(enemyDmgIn), 64'h00FF_0000);
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (moveSCEN) hits++;
    end
    chk("t5_paused_no_move", 64'(hits), 64'd0);

    // Unit target dies during SSCAN.
    enable = 1'b1;
    wait_sig(0, 40, cyc);
    chk("t6_move_lat", 64'(cyc), 64'd8);
    chk("t6_ufront", 64'(unitFront), 64'd250);
    @(negedge clk);
    chk("t6_move_width", 64'(moveSCEN), 64'd0);
    unitType[3:2] = 2'b00;
    wait_sig(1, 40, cyc);
    chk("t6_dmg_lat", 64'(cyc), 64'd4);
    chk("t6_udmgin", 64'(unitDmgIn),  64'd0);
    chk("t6_edmgin", 64'(enemyDmgIn), 64'h00C0_0000);
    @(negedge clk);
    chk("t6_dmg_width", 64'(damageSCEN), 64'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
